// File: rtl/gcd_operand_sequencer.sv
// gcd_operand_sequencer: valid/ready front-end that feeds operand pairs to a subtractive GCD core and returns its result
// Ports: clk/rst_n (async active-low); in_valid/in_a/in_b/in_ready operand handshake;
//        core_start/core_data/core_clear drive the core, core_done/core_result come back;
//        res_valid/res_data/res_err/res_ready result handshake; busy high outside IDLE.
// Optional build macro GCD_ZERO_BYPASS_EN: resolve zero operands locally (gcd(x,0)=x) instead of flagging an error.
module gcd_operand_sequencer #(
    parameter int WIDTH   = 16,
    parameter int MAX_CYC = 70000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             in_ready,
    output logic             core_start,
    output logic [WIDTH-1:0] core_data,
    output logic             core_clear,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_result,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err,
    input  logic             res_ready,
    output logic             busy
);
    localparam int CW = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, WAIT, CLEAR, OUT} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic             err_q;
    logic [CW-1:0]    cnt;
    logic             zero_in, timeout;
    logic [WIDTH-1:0] zero_res;
    logic             zero_err;

    assign zero_in = (in_a == '0) || (in_b == '0);
    assign timeout = cnt == CW'(MAX_CYC - 1);

`ifdef GCD_ZERO_BYPASS_EN
    // The non-zero operand is the GCD; both zero yields zero
    assign zero_res = (in_a == '0) ? in_b : in_a;
    assign zero_err = 1'b0;
`else
    assign zero_res = '0;
    assign zero_err = 1'b1;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_valid ? (zero_in ? OUT : LOAD_A) : IDLE;
            LOAD_A:  state_nx = LOAD_B;
            LOAD_B:  state_nx = WAIT;
            WAIT:    state_nx = (core_done || timeout) ? CLEAR : WAIT;
            CLEAR:   state_nx = OUT;
            OUT:     state_nx = res_ready ? IDLE : OUT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (in_valid) begin
                    a_q <= in_a;
                    b_q <= in_b;
                    if (zero_in) begin
                        res_q <= zero_res;
                        err_q <= zero_err;
                    end
                end
                LOAD_B: cnt <= '0;
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    // core_done takes priority over a coincident timeout
                    if (core_done) begin
                        res_q <= core_result;
                        err_q <= 1'b0;
                    end else if (timeout) begin
                        res_q <= '0;
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = state == IDLE;
    assign busy       = state != IDLE;
    assign core_start = state == LOAD_A;
    assign core_clear = state == CLEAR;
    assign res_valid  = state == OUT;
    assign core_data  = (state == LOAD_A) ? a_q : (state == LOAD_B) ? b_q : '0;
    assign res_data   = res_q;
    assign res_err    = err_q;
endmodule

// File: tb/tb_gcd_operand_sequencer.sv
// tb_gcd_operand_sequencer: directed bench for gcd_operand_sequencer with a behavioural subtractive core and result scoreboard
module tb_gcd_operand_sequencer;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_a = '0, in_b = '0;
    logic         in_ready, core_start, core_clear, core_done;
    logic [W-1:0] core_data, core_result, res_data;
    logic         res_valid, res_err, busy;
    logic         res_ready = 1'b0;
    logic         hang = 1'b0;

    int n_chk = 0, n_fail = 0, n_start = 0, n_clr = 0;
    logic [W:0] sb[$];

    gcd_operand_sequencer #(.WIDTH(W), .MAX_CYC(20)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .in_ready(in_ready), .core_start(core_start), .core_data(core_data),
        .core_clear(core_clear), .core_done(core_done), .core_result(core_result),
        .res_valid(res_valid), .res_data(res_data), .res_err(res_err),
        .res_ready(res_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural core: load A on start, B next cycle, subtract until equal, hold done until cleared
    logic [1:0]   cst;
    logic [W-1:0] cx, cy;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cst <= 2'd0;
        else if (core_clear) cst <= 2'd0;
        else case (cst)
            2'd0: if (core_start) begin cx <= core_data; cst <= 2'd1; end
            2'd1: begin cy <= core_data; cst <= 2'd2; end
            2'd2: if (!hang) begin
                if (cx == cy) cst <= 2'd3;
                else if (cx > cy) cx <= cx - cy;
                else cy <= cy - cx;
            end
            default: ;
        endcase
    end
    assign core_done   = cst == 2'd3;
    assign core_result = cx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (core_start) n_start++;
        if (core_clear) n_clr++;
        if (rst_n && res_valid && res_ready) begin
            if (sb.size() == 0) chk("unexpected_result", 32'(res_valid), 32'd0);
            else begin
                logic [W:0] e;
                e = sb.pop_front();
                chk("res_data", 32'(res_data), 32'(e[W-1:0]));
                chk("res_err", 32'(res_err), 32'(e[W]));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit push,
                        input logic [W-1:0] exp_d, input logic exp_e);
        int i;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        if (push) sb.push_back({exp_e, exp_d});
        i = 0;
        @(negedge clk);
        while (!in_ready && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_res(input int lim);
        for (int i = 0; i < lim && !res_valid; i++) cyc(1);
        chk("res_valid_wait", 32'(res_valid), 32'd1);
    endtask

    task automatic accept;
        res_ready = 1'b1;
        cyc(1);
        res_ready = 1'b0;
    endtask

    initial begin
        int s0, c0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_start", 32'(core_start), 32'd0);
        chk("rst_clear", 32'(core_clear), 32'd0);
        chk("rst_core_data", 32'(core_data), 32'd0);
        chk("rst_res", 32'({res_err, res_data}), 32'd0);
        rst_n = 1'b1;
        cyc(2);

        // 12,18 -> 6
        c0 = n_clr;
        send(12, 18, 1'b1, 6, 1'b0);
        chk("la_start", 32'(core_start), 32'd1);
        chk("la_data", 32'(core_data), 32'd12);
        cyc(1);
        chk("lb_start", 32'(core_start), 32'd0);
        chk("lb_data", 32'(core_data), 32'd18);
        wait_res(40);
        chk("clear_once", 32'(n_clr - c0), 32'd1);
        accept();

        // 35,14 -> 7 with consumer stall
        send(35, 14, 1'b1, 7, 1'b0);
        wait_res(40);
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", 32'(res_valid), 32'd1);
            chk("stall_data", 32'(res_data), 32'd7);
            chk("stall_err", 32'(res_err), 32'd0);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            cyc(1);
        end
        accept();
        chk("idle_after_accept", 32'(in_ready), 32'd1);
        chk("valid_drop", 32'(res_valid), 32'd0);

        // zero operand
        s0 = n_start;
`ifdef GCD_ZERO_BYPASS_EN
        send(0, 9, 1'b1, 9, 1'b0);
`else
        send(0, 9, 1'b1, 0, 1'b1);
`endif
        chk("zero_valid_next", 32'(res_valid), 32'd1);
        accept();
        chk("zero_no_start", 32'(n_start - s0), 32'd0);

        // watchdog: 20 WAIT cycles then CLEAR, then OUT
        hang = 1'b1;
        c0 = n_clr;
        send(5, 3, 1'b1, 0, 1'b1);
        cyc(22);
        chk("to_not_yet", 32'(res_valid), 32'd0);
        chk("to_clear", 32'(core_clear), 32'd1);
        cyc(1);
        chk("to_valid", 32'(res_valid), 32'd1);
        chk("to_clear_once", 32'(n_clr - c0), 32'd1);
        accept();
        hang = 1'b0;

        // async reset during WAIT discards the pair
        hang = 1'b1;
        send(50, 7, 1'b0, 0, 1'b0);
        cyc(5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_valid", 32'(res_valid), 32'd0);
        cyc(1);
        rst_n = 1'b1;
        hang = 1'b0;
        cyc(1);
        send(8, 12, 1'b1, 4, 1'b0);
        wait_res(40);
        accept();

        // back-to-back with consumer always ready
        res_ready = 1'b1;
        s0 = n_start;
        send(9, 6, 1'b1, 3, 1'b0);
        send(17, 5, 1'b1, 1, 1'b0);
        send(100, 75, 1'b1, 25, 1'b0);
        for (int i = 0; i < 200 && sb.size() != 0; i++) cyc(1);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("b2b_starts", 32'(n_start - s0), 32'd3);
        cyc(3);
        chk("b2b_idle", 32'(busy), 32'd0);
        res_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/gcd_operand_sequencer.md
Name: gcd_operand_sequencer

Overview:
- Upstream front-end for the subtractive GCD core (controller plus datapath).
- Accepts an operand pair over a valid/ready handshake, then serialises A and B onto the core's shared data-in bus in the two consecutive load cycles the core expects, pulsing start on the first.
- Waits for core done, captures the result, clears the core, and presents the result on a valid/ready output.
- Screens zero operands, which would hang a subtractive core, and enforces a watchdog timeout.

Parameters:
- WIDTH, 16, operand/result bit width.
- MAX_CYC, 70000, watchdog limit in WAIT cycles; the counter is $clog2(MAX_CYC+1) bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_ready  out  1  sequencer can accept a pair.
- core_start  out  1  one-cycle start pulse to the core.
- core_data  out  WIDTH  core data-in bus: A in the LOAD_A cycle, B in the LOAD_B cycle, 0 otherwise.
- core_clear  out  1  one-cycle core return-to-idle pulse.
- core_done  in  1  core finished.
- core_result  in  WIDTH  core GCD value, valid while core_done=1.
- res_valid  out  1  result available.
- res_data  out  WIDTH  GCD result.
- res_err  out  1  result invalid (zero operand without bypass, or timeout).
- res_ready  in  1  consumer accepts the result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, watchdog counter=0, all outputs 0 except in_ready=1. Reset asserted mid-operation aborts immediately. No result is emitted for the aborted pair.
- All outputs are registered or decoded from state only. No combinational path from in_valid or res_ready to any output.

States and transitions:
- IDLE: in_ready=1.
  - On in_valid, latch a_q=in_a and b_q=in_b.
  - If either operand is zero, go to OUT with the zero rule applied.
  - Otherwise go to LOAD_A.
- LOAD_A: core_start=1, core_data=a_q. Next state LOAD_B.
- LOAD_B: core_data=b_q. Next state WAIT; clear the watchdog counter.
- WAIT: increment the watchdog each cycle.
  - On core_done=1: capture res_q=core_result, err_q=0, go to CLEAR.
  - Else if counter==MAX_CYC-1: res_q=0, err_q=1, go to CLEAR.
  - If core_done and the timeout coincide, core_done wins.
- CLEAR: core_clear=1 for exactly one cycle. Next state OUT.
- OUT: res_valid=1, with res_data=res_q and res_err=err_q held stable.
  - On res_ready=1, go to IDLE.
  - res_valid drops the cycle after acceptance.

Timing and ordering:
- Minimum latency from in_valid&in_ready to res_valid is 4 + core cycles (LOAD_A, LOAD_B, ≥1 WAIT, CLEAR).
- Zero-operand path: res_valid rises the cycle after acceptance.
- Back-to-back pairs: in_ready returns the cycle after res_ready is accepted. Throughput is one pair per transaction; there is no overlap.
- core_done seen outside WAIT is ignored.

Zero rule (without bypass): if a_q==0 or b_q==0, res_data=0 and res_err=1, and the core is never started.

Optional Feature:
- Macro: GCD_ZERO_BYPASS_EN.
- Defined: zero operands are resolved locally without engaging the core, with res_err=0.
  - gcd(x,0)=x.
  - gcd(0,y)=y.
  - gcd(0,0)=0.
- Undefined: the zero rule above applies (res_data=0, res_err=1).
- Both builds: non-zero pairs behave identically.

Test Plan:
- in_a=12, in_b=18 with a behavioural subtractive core model:
  - core_start high one cycle with core_data=12, then core_data=18 the next cycle.
  - Then res_valid=1, res_data=6, res_err=0, core_clear pulsed once before res_valid.
- in_a=35, in_b=14, res_ready held 0 for 10 cycles: res_valid, res_data=7 and res_err stay stable; in_ready=0 throughout; IDLE entered one cycle after res_ready=1.
- in_a=0, in_b=9, both builds:
  - Bypass build: res_data=9, res_err=0.
  - Default build: res_data=0, res_err=1.
  - In both builds core_start never asserts.
- MAX_CYC=20, core model never asserts core_done: res_valid after the 20th WAIT cycle with res_data=0, res_err=1, core_clear pulsed.
- rst_n pulsed low during WAIT: in_ready=1, busy=0 and res_valid=0 immediately (async). A subsequent pair 8,12 yields 4 normally.
- Three back-to-back pairs (9,6)→3, (17,5)→1, (100,75)→25 with res_ready tied 1: results come in order, each exactly once, with no dropped or duplicated core_start.
